// File: rtl/interface_hcsr04_uc.sv
// interface_hcsr04_uc: Moore control FSM sequencing one HC-SR04 measurement with watchdogs and holdoff
module interface_hcsr04_uc #(
  parameter int TIMEOUT_ESPERA = 50_000,
  parameter int TIMEOUT_MEDIDA = 1_250_000,
  parameter int HOLDOFF        = 3_000_000
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_medir,
  input  logic       i_echo,
  input  logic       i_fim_medida,
  output logic       o_zera,
  output logic       o_gera,
  output logic       o_registra,
  output logic       o_pronto,
  output logic       o_erro,
  output logic [3:0] o_db_estado
);
  localparam int MAX_EM = (TIMEOUT_ESPERA > TIMEOUT_MEDIDA) ? TIMEOUT_ESPERA : TIMEOUT_MEDIDA;
  localparam int MAX_T  = (MAX_EM > HOLDOFF) ? MAX_EM : HOLDOFF;
  localparam int W      = $clog2(MAX_T) + 1;
  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARA       = 4'h1,
    ENVIA_TRIGGER = 4'h2,
    ESPERA_ECHO   = 4'h3,
    MEDIDA        = 4'h4,
    ARMAZENA      = 4'h5,
    FINAL         = 4'h6,
    HOLDOFF_ST    = 4'h7,
    ERRO          = 4'hE
  } t_estado;
  t_estado        r_estado, w_prox;
  logic [W-1:0]   r_timer;
  // state register; the timer restarts on every state change, so it reads 0 on entry to each timed state
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_estado <= INICIAL;
      r_timer  <= '0;
    end else begin
      r_estado <= w_prox;
      r_timer  <= (w_prox != r_estado) ? '0 : r_timer + 1'b1;
    end
  end
  // next-state logic; progress conditions are tested before their watchdogs
  always_comb begin
    w_prox = INICIAL;
    case (r_estado)
      INICIAL:       w_prox = i_medir ? PREPARA : INICIAL;
      PREPARA:       w_prox = ENVIA_TRIGGER;
      ENVIA_TRIGGER: w_prox = ESPERA_ECHO;
      ESPERA_ECHO:   w_prox = i_echo ? MEDIDA :
                              (r_timer == W'(TIMEOUT_ESPERA - 1)) ? ERRO : ESPERA_ECHO;
      MEDIDA:        w_prox = i_fim_medida ? ARMAZENA :
                              (r_timer == W'(TIMEOUT_MEDIDA - 1)) ? ERRO : MEDIDA;
      ARMAZENA:      w_prox = FINAL;
      FINAL:         w_prox = HOLDOFF_ST;
      HOLDOFF_ST:    w_prox = (r_timer == W'(HOLDOFF - 1)) ? INICIAL : HOLDOFF_ST;
      ERRO:          w_prox = HOLDOFF_ST;
      default:       w_prox = INICIAL;
    endcase
  end
  assign o_zera      = (r_estado == PREPARA);
  assign o_gera      = (r_estado == ENVIA_TRIGGER);
  assign o_registra  = (r_estado == ARMAZENA);
  assign o_pronto    = (r_estado == FINAL);
  assign o_erro      = (r_estado == ERRO);
  assign o_db_estado = r_estado;
endmodule

// File: tb/tb_interface_hcsr04_uc.sv
// tb_interface_hcsr04_uc: vector table plus random measurements checked against a trace-level reference model
module tb_interface_hcsr04_uc;
  localparam int TE = 20, TM = 100, TH = 30;
  logic       clk = 1'b0, rst_n = 1'b0, medir = 1'b0, echo = 1'b0, fim = 1'b0;
  logic       zera, gera, registra, pronto, erro;
  logic [3:0] db;
  int         checks = 0, errors = 0;
  int         exp_q[$];
  typedef struct {
    int e;
    int f;
    int mode;
    bit early;
    int gap;
    bit exp_p;
  } vec_t;
  vec_t vecs[11];

  always #5 clk = ~clk;

  interface_hcsr04_uc #(.TIMEOUT_ESPERA(TE), .TIMEOUT_MEDIDA(TM), .HOLDOFF(TH)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_medir(medir), .i_echo(echo), .i_fim_medida(fim),
    .o_zera(zera), .o_gera(gera), .o_registra(registra), .o_pronto(pronto), .o_erro(erro),
    .o_db_estado(db)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input int code);
    chk({tag, " db_estado"}, 32'(db), 32'(code));
    chk({tag, " zera"}, 32'(zera), 32'(code == 1));
    chk({tag, " gera"}, 32'(gera), 32'(code == 2));
    chk({tag, " registra"}, 32'(registra), 32'(code == 5));
    chk({tag, " pronto"}, 32'(pronto), 32'(code == 6));
    chk({tag, " erro"}, 32'(erro), 32'(code == 14));
  endtask

  // expected state after each edge from the request edge onward, from the state durations alone
  function automatic void build(input int e, input int f);
    exp_q.delete();
    exp_q.push_back(1);
    exp_q.push_back(2);
    for (int i = 0; i < ((e > TE) ? TE : e); i++) exp_q.push_back(3);
    if (e > TE) exp_q.push_back(14);
    else begin
      for (int i = 0; i < ((f > TM) ? TM : f); i++) exp_q.push_back(4);
      if (f > TM) exp_q.push_back(14);
      else begin
        exp_q.push_back(5);
        exp_q.push_back(6);
      end
    end
    for (int i = 0; i < TH; i++) exp_q.push_back(7);
    exp_q.push_back(0);
  endfunction

  // e = ESPERA_ECHO cycles before echo is seen, f = MEDIDA cycles before fim_medida is seen
  task automatic run(input int e_in, input int f, input int mode, input bit early, input int gap, input bit exp_p);
    int np = 0, ne = 0;
    int e = early ? 1 : e_in;
    build(e, f);
    for (int n = 0; n < exp_q.size(); n++) begin
      medir = (n == 0) ? 1'b1 : (mode == 2) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      echo  = (early || n >= 2 + e) && n <= 2 + e + f;
      fim   = (n == 2 + e + f);
      @(posedge clk);
      #1;
      chk_outs("trace", exp_q[n]);
      np += int'(pronto);
      ne += int'(erro);
    end
    chk("pronto count", 32'(np), 32'(exp_p));
    chk("erro count", 32'(ne), 32'(!exp_p));
    echo = 1'b0;
    fim  = 1'b0;
    if (gap > 0) medir = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
      chk_outs("idle", 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int np, ne;
    vecs = '{
      '{4, 40, 0, 1'b0, 2, 1'b1},
      '{25, 0, 0, 1'b0, 2, 1'b0},
      '{3, 200, 1, 1'b0, 2, 1'b0},
      '{4, 100, 0, 1'b0, 2, 1'b1},
      '{20, 1, 0, 1'b0, 2, 1'b1},
      '{21, 5, 0, 1'b0, 2, 1'b0},
      '{2, 101, 0, 1'b0, 2, 1'b0},
      '{1, 1, 0, 1'b1, 0, 1'b1},
      '{6, 10, 2, 1'b0, 0, 1'b1},
      '{6, 10, 2, 1'b0, 0, 1'b1},
      '{3, 30, 1, 1'b0, 3, 1'b1}
    };
    medir = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_outs("in reset", 0);
    rst_n = 1'b1;
    medir = 1'b0;
    @(posedge clk);
    #1;
    chk_outs("after reset", 0);
    foreach (vecs[i]) run(vecs[i].e, vecs[i].f, vecs[i].mode, vecs[i].early, vecs[i].gap, vecs[i].exp_p);
    for (int i = 0; i < 12; i++) begin
      int e = int'($urandom_range(1, 24));
      int f = int'($urandom_range(1, 105));
      int mode = int'($urandom_range(0, 2));
      run(e, f, mode, 1'b0, (mode == 2) ? 0 : int'($urandom_range(0, 3)), e <= TE && f <= TM);
    end
    medir = 1'b0;
    @(posedge clk);
    #1;
    chk_outs("pre abort", 0);
    medir = 1'b1;
    @(posedge clk);
    #1;
    chk_outs("abort prepara", 1);
    medir = 1'b0;
    echo  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_outs("abort medida", 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("async reset", 0);
    np = 0;
    ne = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      np += int'(pronto);
      ne += int'(erro);
    end
    rst_n = 1'b1;
    echo  = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      np += int'(pronto);
      ne += int'(erro);
      chk_outs("post abort", 0);
    end
    chk("abort pronto count", 32'(np), 32'd0);
    chk("abort erro count", 32'(ne), 32'd0);
    run(5, 40, 0, 1'b0, 1, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
